// File: rtl/fifo_pkg.sv
// Shared constants and drain-FSM encoding for the push/pop FIFO family.
package fifo_pkg;
  localparam int MSBD_DEF = 3;
  localparam int LAST_DEF = 15;
  localparam int MSBA_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;
endpackage

// File: rtl/drain_skid.sv
// Two-entry skid buffer; head register drives the output stream.
module drain_skid #(
  parameter int MSBD = fifo_pkg::MSBD_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [MSBD:0] in_data,
  input  logic          outReady,
  output logic [1:0]    occ,
  output logic          outValid,
  output logic [MSBD:0] outData
);
  logic [MSBD:0] head, tail;
  logic          deq;

  assign deq      = outValid & outReady;
  assign outValid = (occ != 2'd0);
  assign outData  = head;

  // Producer never fills past two entries, so occ==2 with in_valid only cannot occur.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({in_valid, deq})
        2'b10: begin
          if (occ == 2'd0) head <= in_data;
          else             tail <= in_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) head <= in_data;
          else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_drain.sv
// Read-side burst master: pops N entries from a push/pop FIFO into a skid-buffered stream.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int MSBD = fifo_pkg::MSBD_DEF,
  parameter int LAST = fifo_pkg::LAST_DEF,
  parameter int MSBA = fifo_pkg::MSBA_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [MSBA+1:0] burstLen,
  input  logic [MSBD:0]   fifoData,
  input  logic            fifoEmpty,
  input  logic            fifoFull,
  input  logic            pushSeen,
  output logic            pop,
  output logic [MSBD:0]   outData,
  output logic            outValid,
  input  logic            outReady,
  output logic            busy,
  output logic            done,
  output logic [MSBA+1:0] drained
);
  localparam int CW    = MSBA + 2;
  localparam int DEPTH = LAST + 1;

  if (DEPTH > (1 << (MSBA + 1))) begin : g_bad_cfg
    $error("fifo_drain: FIFO depth does not fit the address width");
  end

  drain_state_e  state;
  logic [CW-1:0] remaining;
  logic [CW-1:0] rem_next;
  logic [1:0]    occ;
  logic          honored, deq, skid_empty_next;

  // pop looks only at registered state and fifoEmpty; outReady never reaches it.
  assign pop = (state == DRAIN) & ~fifoEmpty & (occ < 2'd2) & (remaining != '0);

  // A simultaneous push wins inside the FIFO, so that pop is dropped and retried.
  assign honored  = pop & ~(pushSeen & ~fifoFull);
  assign deq      = outValid & outReady;
  assign rem_next = remaining - {{(CW-1){1'b0}}, honored};

  // FLUSH never pops, so the buffer empties this edge iff the last entry leaves now.
  assign skid_empty_next = (occ == 2'd0) | ((occ == 2'd1) & deq);

  drain_skid #(.MSBD(MSBD)) u_skid (
    .clock    (clock),
    .reset    (reset),
    .in_valid (honored),
    .in_data  (fifoData),
    .outReady (outReady),
    .occ      (occ),
    .outValid (outValid),
    .outData  (outData)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      drained   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (deq && drained != '1) drained <= drained + 1'b1;
      if (honored) remaining <= rem_next;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= burstLen;
            drained   <= '0;
            busy      <= 1'b1;
            if (burstLen != '0) state <= DRAIN;
            else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rem_next == '0) state <= FLUSH;
        end
        FLUSH: begin
          if (skid_empty_next) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side master for the push/pop FIFO interface used by the shift-register and ring-buffer FIFOs. It drains a requested number of entries from the FIFO, issues `pop`, and captures `dataOut` in the same cycle. Captured data is forwarded through a 2-entry skid buffer onto a valid/ready stream. It sits between either FIFO implementation and a downstream consumer, and is written so that either FIFO can be substituted without changing it.

## Interface
- MSBD, 3, MSB index of data word (width MSBD+1)
- LAST, 15, index of last FIFO entry (depth LAST+1)
- MSBA, 3, MSB index of FIFO address; burst/count width is MSBA+2
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a burst; sampled only in IDLE
- burstLen  in  MSBA+2  number of entries to drain; 0 is legal
- fifoData  in  MSBD+1  FIFO `dataOut`; meaningful only when fifoEmpty=0
- fifoEmpty  in  1  FIFO empty flag
- fifoFull  in  1  FIFO full flag
- pushSeen  in  1  copy of the writer's `push` into the same FIFO
- pop  out  1  pop request to FIFO (combinational)
- outData  out  MSBD+1  head of skid buffer
- outValid  out  1  skid buffer non-empty
- outReady  in  1  downstream accepts when outValid&outReady
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion
- drained  out  MSBA+2  entries delivered downstream in the current or last burst

## Operation
- FSM states: IDLE, DRAIN, FLUSH, DONE.
  - IDLE: on `start`, latch `remaining=burstLen` and clear `drained`. Go to DRAIN if burstLen≠0, else DONE.
  - DRAIN: `pop = ~fifoEmpty & (occ<2) & (remaining≠0)`. When `remaining` reaches 0, go to FLUSH.
  - FLUSH: no pops. When `occ==0`, go to DONE.
  - DONE: `done=1` for exactly this cycle, then go to IDLE.
- A pop is *honored* iff `pop & ~fifoEmpty & ~(pushSeen & ~fifoFull)`. This follows the FIFO rule that push wins when both are asserted.
  - Only an honored pop captures `fifoData` into the skid buffer and decrements `remaining`.
  - A pop that is not honored is dropped silently and retried in a later cycle. No duplicate or lost entries are allowed.
- Skid buffer occupancy `occ` ∈ {0,1,2}. Per cycle, occ changes by +1 for an honored pop and −1 for an output handshake; both may occur in the same cycle.
- FIFO order is preserved: outData is always the oldest captured entry.
- `drained` increments on each output handshake and saturates at 2^(MSBA+2)−1.
- `start` outside IDLE is ignored.
- Reset values: FSM=IDLE, occ=0, outValid=0, outData=0, busy=0, done=0, drained=0, remaining=0. `pop` is 0 during and after reset until DRAIN is entered.
- Reset mid-burst flushes the skid buffer and abandons the burst. Entries already popped are lost; this is by design.
- Properties for the bench:
  - When `outValid & ~outReady` holds, outValid and outData are held in the next cycle.
  - No pop is issued while fifoEmpty=1.
  - occ never exceeds 2.

## Timing
- Pop to output latency: an entry honored at edge t appears on outData/outValid in the cycle after t.
- Throughput: one entry per cycle when outReady stays high and the writer is not pushing.
- `done` is asserted one cycle after the last output handshake. For burstLen=0, it is asserted one cycle after start is sampled.
- `busy` goes high the cycle after start is sampled and goes low the cycle after done.
- `pop` depends combinationally on fifoEmpty and registered state only. It does not depend on outReady, so there is no combinational path from outReady to pop.

## Structure
- Package `fifo_pkg`:
  - FSM state encoding (IDLE=0, DRAIN=1, FLUSH=2, DONE=3)
  - Default MSBD/LAST/MSBA constants shared with the FIFOs
- Sub-module `drain_skid`: a 2-entry skid buffer.
  - Inputs: `in_valid` (honored pop), `in_data`.
  - Outputs: `occ`, `outValid`, `outData`; accepts `outReady`.
- `fifo_drain` contains the FSM, the `remaining`/`drained` counters, and the honored-pop logic.

## Test plan
- Preload FIFO with A,B,C; start with burstLen=3 and outReady=1 → pop high for 3 cycles; outData=A,B,C on consecutive cycles; done pulses once; drained=3.
- Same preload with outReady=0 → exactly 2 pops, then pop=0 and outData holds A. Raising outReady → A,B,C in order, 3rd pop issued, done, drained=3.
- burstLen=2 with the writer asserting push (FIFO not full) in the first pop cycle → that pop is not counted and is retried; output is exactly the 2 oldest entries with no duplicate.
- burstLen=0 → no pop; done pulses 1 cycle after start; drained=0.
- burstLen=4 with only 2 entries present → pop stays low while fifoEmpty=1. After 2 more pushes, the burst completes with 4 ordered entries.
- Assert reset mid-DRAIN with occ=2 → next cycle outValid=0, busy=0, pop=0, drained=0. A fresh start then operates normally.
